mem_dump_reader: RTL
====================

// Module: mem_dump_reader
// PURPOSE
//  Read-side counterpart of the bench program loader: after a CPU run, streams a contiguous RAM region out
//  as bytes for result checking. Owns the generic_ram port while busy (bus_own drives the top-level mux),
//  issues one read per cycle under credit control, buffers returning data in a small FIFO and presents it
//  on a valid/ready byte stream with a last flag. One clock; asynchronous active-high reset.
// PARAMETERS
//  ADDR_W      16  RAM address width; addresses wrap modulo 2**ADDR_W
//  LEN_W       16  width of length request / internal byte counters
//  FIFO_DEPTH  4   output buffer entries (power of 2, >= 2)
//  RD_LAT      1   RAM read latency in cycles (registered read = 1)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       asynchronous reset, active high
//  start        in   1       request pulse; sampled only when busy=0
//  base_addr    in   ADDR_W  first address, latched on accepted start
//  length       in   LEN_W   byte count, latched on accepted start; 0 = empty dump
//  busy         out  1       high from accepted start until done
//  done         out  1       one-cycle pulse when dump finished
//  bus_own      out  1       high while reader owns RAM port (= busy)
//  mem_addr     out  ADDR_W  RAM read address
//  mem_read_en  out  1       read strobe; one byte requested per high cycle
//  mem_data_in  in   8       RAM read data, valid RD_LAT cycles after mem_read_en
//  out_data     out  8       stream byte (FIFO head)
//  out_valid    out  1       stream byte valid
//  out_ready    in   1       sink ready; transfer when out_valid & out_ready
//  out_last     out  1       qualifies final byte of the dump
// BEHAVIOUR
//  Reset (async, any time incl. mid-dump): state IDLE, all outputs 0, FIFO emptied, counters 0, in-flight
//   reads discarded (returning data ignored). Release synchronous to clk.
//  FSM: IDLE -> (start, length!=0) ISSUE -> (all reads issued) DRAIN -> (last byte transferred) FIN -> IDLE.
//   IDLE -> (start, length==0) FIN directly: busy high 1 cycle, done pulses, no reads, no stream bytes.
//  FIN lasts exactly one cycle: done=1, busy=1; next cycle busy=0, bus_own=0.
//  busy/bus_own assert the cycle after accepted start; start while busy ignored (no relatch).
//  Issue rule: mem_read_en=1 in ISSUE when issued < length and
//   (FIFO occupancy + reads in flight) < FIFO_DEPTH; never overflow, no data dropped.
//  mem_addr = base_addr + issued (mod 2**ADDR_W): 0xFFFF wraps to 0x0000. mem_addr held when not reading.
//  Return capture: data written to FIFO tail RD_LAT cycles after each read strobe (delay-line of strobes).
//  Stream: out_valid = FIFO non-empty; out_data/out_last stable while out_valid & !out_ready.
//  out_last = 1 exactly on byte index length-1 (count of transferred bytes, not issued).
//  Simultaneous FIFO write and read in one cycle: occupancy unchanged, both take effect.
//  Throughput: with out_ready held 1, one byte per cycle; first out_valid RD_LAT+1 cycles after start.
//  Max length 2**LEN_W-1; counters LEN_W bits, no overflow possible.
// TESTING
//  1 RAM[0x0300..0x0303]=11,22,33,44; start base=0x0300 len=4, out_ready=1 -> bytes 11,22,33,44 on 4
//    consecutive cycles, out_last only on 44, done pulse next cycle, busy then 0.
//  2 len=0 start -> busy high 1 cycle with done=1, mem_read_en never asserted, out_valid never 1.
//  3 base=0xFFFE len=4, RAM[FFFE]=A1,[FFFF]=A2,[0000]=A3,[0001]=A4 -> mem_addr FFFE,FFFF,0000,0001;
//    stream A1,A2,A3,A4.
//  4 len=16, out_ready low 20 cycles then high -> exactly FIFO_DEPTH reads issued while stalled, no loss,
//    all 16 bytes in order, out_data stable during stall; random out_ready toggling gives same sequence.
//  5 start again while busy with base=0x0000 -> ignored; original dump completes unchanged.
//  6 assert rst mid-dump (after 3 bytes of 8) -> outputs 0 immediately; new start base=0x0200 len=2 after
//    release streams RAM[0x0200],RAM[0x0201] with no stale bytes.

Source files
------------

// File: rtl/mem_dump_reader.sv
// Streams a contiguous RAM region out as a valid/ready byte stream after a CPU run.
// Owns the RAM port while busy and throttles reads so the small output FIFO can never overflow.
module mem_dump_reader #(
    parameter int ADDR_W     = 16,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              bus_own,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    input  logic [7:0]        mem_data_in,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issued;
    logic [LEN_W-1:0]  r_sent;
    logic [RD_LAT-1:0] r_strb;
    logic [7:0]        r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_inflight;

    logic              w_accept;
    logic              w_rd_en;
    logic              w_capture;
    logic              w_pop;
    logic              w_last_issue;
    logic              w_last_byte;
    logic [CNT_W:0]    w_occ;

    assign w_accept     = (r_state == S_IDLE) && start;
    assign w_capture    = r_strb[RD_LAT-1];
    assign w_pop        = out_valid && out_ready;
    // Reads still in the RAM pipe already own a FIFO slot, so they count against capacity.
    assign w_occ        = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_rd_en      = (r_state == S_ISSUE) && (r_issued < r_len) &&
                          (w_occ < (CNT_W+1)'(FIFO_DEPTH));
    assign w_last_issue = (r_issued == r_len - LEN_W'(1));
    assign w_last_byte  = (r_sent == r_len - LEN_W'(1));

    assign busy        = (r_state != S_IDLE);
    assign bus_own     = busy;
    assign done        = (r_state == S_FIN);
    assign mem_addr    = r_addr;
    assign mem_read_en = w_rd_en;
    assign out_valid   = (r_count != '0);
    assign out_data    = out_valid ? r_fifo[r_rd_ptr] : 8'h00;
    assign out_last    = out_valid && w_last_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (length == '0) ? S_FIN : S_ISSUE;
            S_ISSUE: if (w_rd_en && w_last_issue) w_next = S_DRAIN;
            S_DRAIN: if (w_pop && w_last_byte) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_len    <= '0;
            r_issued <= '0;
            r_sent   <= '0;
        end else if (w_accept) begin
            r_addr   <= base_addr;
            r_len    <= length;
            r_issued <= '0;
            r_sent   <= '0;
        end else begin
            if (w_rd_en) begin
                r_addr   <= r_addr + ADDR_W'(1);
                r_issued <= r_issued + LEN_W'(1);
            end
            if (w_pop) begin
                r_sent <= r_sent + LEN_W'(1);
            end
        end
    end

    // Strobe delay line marks the cycle each requested byte appears on mem_data_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strb     <= '0;
            r_inflight <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_strb     <= (r_strb << 1) | RD_LAT'(w_rd_en);
            r_inflight <= r_inflight + CNT_W'(w_rd_en) - CNT_W'(w_capture);
            r_count    <= r_count + CNT_W'(w_capture) - CNT_W'(w_pop);
            if (w_capture) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_fifo[r_wr_ptr] <= mem_data_in;
        end
    end

endmodule
